// File: rtl/snake_grid_render_if.sv
// Bus between the snake state engine / display and snake_grid_render.
//   snake_in     packed segment bytes {y,x}, byte0 = tail, 8'h00 terminates
//   write_snake  snapshot request (level), honoured only while the renderer is idle
//   rd_y, rd_x   display read coordinates
//   rd_cell      00 empty, 01 body, 10 head (combinational from the front buffer)
//   head_y/x, head_valid, seg_count   published frame summary
//   busy, frame_done, overrun, self_hit   status
// master: snake engine + display side. slave: the renderer.
interface snake_grid_render_if #(
    parameter int MAX_SEGS = 225,
    parameter int COORD_W  = 4
);
    logic [MAX_SEGS*8-1:0] snake_in;
    logic                  write_snake;
    logic [COORD_W-1:0]    rd_y;
    logic [COORD_W-1:0]    rd_x;
    logic [1:0]            rd_cell;
    logic [COORD_W-1:0]    head_y;
    logic [COORD_W-1:0]    head_x;
    logic                  head_valid;
    logic [7:0]            seg_count;
    logic                  busy;
    logic                  frame_done;
    logic                  overrun;
    logic                  self_hit;

    modport master (
        output snake_in, write_snake, rd_y, rd_x,
        input  rd_cell, head_y, head_x, head_valid, seg_count,
               busy, frame_done, overrun, self_hit
    );

    modport slave (
        input  snake_in, write_snake, rd_y, rd_x,
        output rd_cell, head_y, head_x, head_valid, seg_count,
               busy, frame_done, overrun, self_hit
    );
endinterface

// File: rtl/snake_grid_render.sv
// snake_grid_render: snapshots the packed snake body, rasterises it into a
// 16x16 occupancy grid (back buffer) and publishes it to a front buffer that
// the display reads combinationally.
// Ports:
//   slw_clk   clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       snake_grid_render_if.slave (snapshot input, display read, status)
// Optional feature macro: SNAKE_SELF_HIT_EN enables self-collision detection
// during the scan; without it self_hit is tied to 0.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for write_snake; captures snapshot
// ST_CLEAR | zeroing one back-grid row per cycle, rows 0..GRID-1
// ST_SCAN  | one segment byte per cycle until 8'h00 or MAX_SEGS bytes done
// ST_SWAP  | copy back grid + scan results to the published frame
module snake_grid_render #(
    parameter int MAX_SEGS = 225,
    parameter int COORD_W  = 4
) (
    input  logic                 slw_clk,
    input  logic                 reset_n,
    snake_grid_render_if.slave   bus
);

    localparam int GRID   = 1 << COORD_W;
    localparam int CELLS  = GRID * GRID;
    localparam int SNAP_W = MAX_SEGS * 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_SCAN  = 2'd2;
    localparam logic [1:0] ST_SWAP  = 2'd3;

    logic [1:0]           state;
    logic [SNAP_W-1:0]    snap;
    logic [7:0]           idx;
    logic [COORD_W-1:0]   clr_row;
    logic [CELLS-1:0]     back_grid;
    logic [CELLS-1:0]     front_grid;
    logic [COORD_W-1:0]   scan_hy;
    logic [COORD_W-1:0]   scan_hx;
    logic [COORD_W-1:0]   head_y;
    logic [COORD_W-1:0]   head_x;
    logic                 head_valid;
    logic [7:0]           seg_count;
    logic                 frame_done;

    // The snapshot is shifted down one byte per scanned segment, so the
    // current segment is always in the low byte.
    logic [7:0]           cur_byte;
    logic [COORD_W-1:0]   cur_y;
    logic [COORD_W-1:0]   cur_x;
    logic [2*COORD_W-1:0] cur_cell;
    logic                 seg_live;
    logic                 last_seg;

    assign cur_byte = snap[7:0];
    assign cur_y    = cur_byte[4 +: COORD_W];
    assign cur_x    = cur_byte[0 +: COORD_W];
    assign cur_cell = {cur_y, cur_x};
    assign seg_live = (state == ST_SCAN) && (cur_byte != 8'h00);
    // Stop right after the final legal byte so a full snake needs no extra
    // terminator cycle.
    assign last_seg = (idx == 8'(MAX_SEGS - 1));

    always_ff @(posedge slw_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            snap       <= '0;
            idx        <= '0;
            clr_row    <= '0;
            back_grid  <= '0;
            front_grid <= '0;
            scan_hy    <= '0;
            scan_hx    <= '0;
            head_y     <= '0;
            head_x     <= '0;
            head_valid <= 1'b0;
            seg_count  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.write_snake) begin
                        snap    <= bus.snake_in;
                        idx     <= '0;
                        clr_row <= '0;
                        scan_hy <= '0;
                        scan_hx <= '0;
                        state   <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    back_grid[{clr_row, {COORD_W{1'b0}}} +: GRID] <= '0;
                    clr_row <= clr_row + 1'b1;
                    if (clr_row == COORD_W'(GRID - 1)) begin
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cur_byte == 8'h00) begin
                        state <= ST_SWAP;
                    end else begin
                        back_grid[cur_cell] <= 1'b1;
                        scan_hy <= cur_y;
                        scan_hx <= cur_x;
                        idx     <= idx + 1'b1;
                        snap    <= snap >> 8;
                        if (last_seg) begin
                            state <= ST_SWAP;
                        end
                    end
                end
                ST_SWAP: begin
                    front_grid <= back_grid;
                    head_y     <= scan_hy;
                    head_x     <= scan_hx;
                    seg_count  <= idx;
                    head_valid <= (idx != 8'd0);
                    frame_done <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SNAKE_SELF_HIT_EN
    logic hit_flag;
    logic self_hit;

    always_ff @(posedge slw_clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_flag <= 1'b0;
            self_hit <= 1'b0;
        end else begin
            if (state == ST_IDLE && bus.write_snake) begin
                hit_flag <= 1'b0;
            end else if (seg_live && back_grid[cur_cell]) begin
                hit_flag <= 1'b1;
            end
            if (state == ST_SWAP) begin
                self_hit <= hit_flag;
            end
        end
    end

    assign bus.self_hit = self_hit;
`else
    assign bus.self_hit = 1'b0;
`endif

    logic [2*COORD_W-1:0] rd_cell_idx;
    logic                 rd_is_head;

    assign rd_cell_idx = {bus.rd_y, bus.rd_x};
    assign rd_is_head  = head_valid && (bus.rd_y == head_y) && (bus.rd_x == head_x);

    assign bus.rd_cell    = rd_is_head ? 2'b10 :
                            (front_grid[rd_cell_idx] ? 2'b01 : 2'b00);
    assign bus.head_y     = head_y;
    assign bus.head_x     = head_x;
    assign bus.head_valid = head_valid;
    assign bus.seg_count  = seg_count;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.frame_done = frame_done;
    // A request seen while busy is dropped; flag it in the same cycle.
    assign bus.overrun    = bus.write_snake && (state != ST_IDLE);

endmodule
